// File: rtl/pe_mac_vcounter_rs_if.sv
// rtl/pe_mac_vcounter_rs_if.sv - operand, control and result bundle for the MAC processing element
interface pe_mac_vcounter_rs_if #(
    parameter int I_BITS        = 8,
    parameter int MAX_DIMENSION = 16,
    parameter int DIM_BITS      = $clog2(MAX_DIMENSION + 1),
    parameter int ACC_BITS      = 2 * I_BITS + $clog2(MAX_DIMENSION),
    parameter int O_BITS        = 2 * I_BITS,
    parameter int SHIFT_BITS    = $clog2(ACC_BITS - O_BITS + 1)
);
    logic                     i_valid;
    logic [DIM_BITS-1:0]      i_dimension;
    logic [SHIFT_BITS-1:0]    i_shift;
    logic                     i_a_reset;
    logic                     i_b_reset;
    logic signed [I_BITS-1:0] i_a;
    logic signed [I_BITS-1:0] i_b;
    logic                     o_a_reset;
    logic                     o_b_reset;
    logic signed [I_BITS-1:0] o_a;
    logic signed [I_BITS-1:0] o_b;
    logic signed [O_BITS-1:0] o_c;
    logic                     o_c_valid;
    logic                     o_finish;
    logic                     o_overflow;

    modport master (
        output i_valid, i_dimension, i_shift, i_a_reset, i_b_reset, i_a, i_b,
        input  o_a_reset, o_b_reset, o_a, o_b, o_c, o_c_valid, o_finish, o_overflow
    );

    modport slave (
        input  i_valid, i_dimension, i_shift, i_a_reset, i_b_reset, i_a, i_b,
        output o_a_reset, o_b_reset, o_a, o_b, o_c, o_c_valid, o_finish, o_overflow
    );
endinterface

// File: rtl/pe_mac_vcounter_rs.sv
// rtl/pe_mac_vcounter_rs.sv - systolic MAC PE with run-time dot-product length and rounded held result
// Optional saturation of the result to O_BITS is enabled by defining PE_SATURATE_EN.
module pe_mac_vcounter_rs #(
    parameter int I_BITS        = 8,
    parameter int MAX_DIMENSION = 16,
    parameter int DIM_BITS      = $clog2(MAX_DIMENSION + 1),
    parameter int ACC_BITS      = 2 * I_BITS + $clog2(MAX_DIMENSION),
    parameter int O_BITS        = 2 * I_BITS,
    parameter int SHIFT_BITS    = $clog2(ACC_BITS - O_BITS + 1)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pe_mac_vcounter_rs_if.slave   io_bus
);
    localparam int MAX_SHIFT = ACC_BITS - O_BITS;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t                     r_state;
    logic [DIM_BITS-1:0]        r_dim;
    logic [DIM_BITS-1:0]        r_cnt;
    logic signed [ACC_BITS-1:0] r_acc;
    logic signed [I_BITS-1:0]   r_a;
    logic signed [I_BITS-1:0]   r_b;
    logic                       r_a_reset;
    logic                       r_b_reset;
    logic signed [O_BITS-1:0]   r_c;
    logic                       r_c_valid;
    logic                       r_finish;
    logic                       r_overflow;

    logic                       w_soft_rst;
    logic signed [2*I_BITS-1:0] w_prod;
    logic signed [ACC_BITS-1:0] w_prod_ext;
    logic signed [ACC_BITS-1:0] w_sum;
    logic [DIM_BITS-1:0]        w_dim_start;
    logic                       w_last;
    logic [SHIFT_BITS-1:0]      w_shift;
    logic signed [ACC_BITS:0]   w_half;
    logic signed [ACC_BITS:0]   w_rounded;
    logic signed [O_BITS-1:0]   w_c;
    logic                       w_overflow;

    assign w_soft_rst = io_bus.i_a_reset | io_bus.i_b_reset;
    assign w_prod     = (2*I_BITS)'(io_bus.i_a) * (2*I_BITS)'(io_bus.i_b);
    assign w_prod_ext = ACC_BITS'(w_prod);
    // The accumulator is always zero in IDLE, so this is also the single-beat result.
    assign w_sum      = r_acc + w_prod_ext;

    always_comb begin
        w_dim_start = io_bus.i_dimension;
        if (io_bus.i_dimension == '0) begin
            w_dim_start = DIM_BITS'(1);
        end else if (io_bus.i_dimension > DIM_BITS'(MAX_DIMENSION)) begin
            w_dim_start = DIM_BITS'(MAX_DIMENSION);
        end
    end

    assign w_last = (r_state == S_IDLE) ? (w_dim_start == DIM_BITS'(1))
                                        : !((r_cnt + DIM_BITS'(1)) < r_dim);

    // One extra bit of headroom so the rounding increment cannot wrap the sum.
    assign w_shift   = (io_bus.i_shift > SHIFT_BITS'(MAX_SHIFT)) ? SHIFT_BITS'(MAX_SHIFT) : io_bus.i_shift;
    assign w_half    = ((ACC_BITS+1)'(1) << w_shift) >> 1;
    assign w_rounded = ((ACC_BITS+1)'(w_sum) + w_half) >>> w_shift;

`ifdef PE_SATURATE_EN
    localparam logic signed [ACC_BITS:0] SAT_MAX = (ACC_BITS+1)'((1 << (O_BITS - 1)) - 1);
    localparam logic signed [ACC_BITS:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        w_c        = w_rounded[O_BITS-1:0];
        w_overflow = 1'b0;
        if (w_rounded > SAT_MAX) begin
            w_c        = SAT_MAX[O_BITS-1:0];
            w_overflow = 1'b1;
        end else if (w_rounded < SAT_MIN) begin
            w_c        = SAT_MIN[O_BITS-1:0];
            w_overflow = 1'b1;
        end
    end
`else
    logic w_unused_msbs;
    assign w_unused_msbs = ^w_rounded[ACC_BITS:O_BITS];
    assign w_c           = w_rounded[O_BITS-1:0];
    assign w_overflow    = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= S_IDLE;
            r_dim      <= DIM_BITS'(1);
            r_cnt      <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_a_reset  <= 1'b0;
            r_b_reset  <= 1'b0;
            r_c        <= '0;
            r_c_valid  <= 1'b0;
            r_finish   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!io_bus.i_valid) begin
            r_c_valid <= 1'b0;
        end else begin
            r_a_reset <= w_soft_rst;
            r_b_reset <= w_soft_rst;
            r_c_valid <= 1'b0;
            if (w_soft_rst) begin
                r_a     <= '0;
                r_b     <= '0;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_state <= S_IDLE;
            end else begin
                r_a <= io_bus.i_a;
                r_b <= io_bus.i_b;
                if (r_state == S_IDLE) begin
                    r_finish <= 1'b0;
                    r_dim    <= w_dim_start;
                end
                if (w_last) begin
                    r_c        <= w_c;
                    r_overflow <= w_overflow;
                    r_c_valid  <= 1'b1;
                    r_finish   <= 1'b1;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_state    <= S_IDLE;
                end else if (r_state == S_IDLE) begin
                    r_acc   <= w_prod_ext;
                    r_cnt   <= DIM_BITS'(1);
                    r_state <= S_ACCUM;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + DIM_BITS'(1);
                end
            end
        end
    end

    assign io_bus.o_a_reset  = r_a_reset;
    assign io_bus.o_b_reset  = r_b_reset;
    assign io_bus.o_a        = r_a;
    assign io_bus.o_b        = r_b;
    assign io_bus.o_c        = r_c;
    assign io_bus.o_c_valid  = r_c_valid;
    assign io_bus.o_finish   = r_finish;
    assign io_bus.o_overflow = r_overflow;
endmodule

// File: tb/tb_pe_mac_vcounter_rs.sv
// tb/tb_pe_mac_vcounter_rs.sv - scoreboard bench for pe_mac_vcounter_rs with a dot-product reference model
module tb_pe_mac_vcounter_rs;
    localparam int I_BITS        = 8;
    localparam int MAX_DIMENSION = 4;
    localparam int ACC_BITS      = 2 * I_BITS + $clog2(MAX_DIMENSION);
    localparam int O_BITS        = 2 * I_BITS;
    localparam longint SMAX      = (longint'(1) <<< (O_BITS - 1)) - 1;
    localparam longint SMIN      = -(longint'(1) <<< (O_BITS - 1));

    typedef struct {
        int                       cyc;
        logic signed [O_BITS-1:0] c;
        logic                     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q[$];
    int   m_prods[$];
    int   m_dim = 1;
    bit   m_busy = 0;

    logic signed [I_BITS-1:0] exp_a = '0, exp_b = '0;
    logic                     exp_ar = 1'b0, exp_br = 1'b0, exp_fin = 1'b0, exp_ovf = 1'b0;
    logic signed [O_BITS-1:0] exp_c = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pe_mac_vcounter_rs_if #(.I_BITS(I_BITS), .MAX_DIMENSION(MAX_DIMENSION)) bus ();

    pe_mac_vcounter_rs #(.I_BITS(I_BITS), .MAX_DIMENSION(MAX_DIMENSION)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .io_bus  (bus)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, $signed(act), $signed(exp), cyc);
        end
    endfunction

    function automatic void fmt(input longint sum, input int sh, output logic signed [O_BITS-1:0] c, output logic ovf);
        longint r;
        int     s;
        s = (sh > ACC_BITS - O_BITS) ? ACC_BITS - O_BITS : sh;
        if (s == 0) r = sum;
        else        r = (sum + (longint'(1) <<< (s - 1))) >>> s;
        ovf = 1'b0;
`ifdef PE_SATURATE_EN
        if (r > SMAX) begin
            r = SMAX;
            ovf = 1'b1;
        end else if (r < SMIN) begin
            r = SMIN;
            ovf = 1'b1;
        end
`endif
        c = r[O_BITS-1:0];
    endfunction

    // Drive one clock of stimulus, then advance the dot-product model for that edge.
    task automatic beat(input bit v, input int a, input int b, input int dim, input int sh, input bit ar, input bit br);
        logic signed [O_BITS-1:0] c;
        logic                     ovf;
        longint                   sum;
        bus.i_valid     = v;
        bus.i_a         = I_BITS'(a);
        bus.i_b         = I_BITS'(b);
        bus.i_dimension = 3'(dim);
        bus.i_shift     = 2'(sh);
        bus.i_a_reset   = ar;
        bus.i_b_reset   = br;
        @(posedge clk);
        #1;
        if (v) begin
            exp_ar = ar | br;
            exp_br = ar | br;
            if (ar | br) begin
                exp_a = '0;
                exp_b = '0;
                m_prods.delete();
                m_busy = 0;
            end else begin
                exp_a = I_BITS'(a);
                exp_b = I_BITS'(b);
                if (!m_busy) begin
                    m_dim   = (dim == 0) ? 1 : (dim > MAX_DIMENSION) ? MAX_DIMENSION : dim;
                    m_busy  = 1;
                    exp_fin = 1'b0;
                    m_prods.delete();
                end
                m_prods.push_back(a * b);
                if (m_prods.size() == m_dim) begin
                    sum = 0;
                    foreach (m_prods[i]) sum += m_prods[i];
                    fmt(sum, sh, c, ovf);
                    q.push_back('{cyc, c, ovf});
                    exp_c   = c;
                    exp_ovf = ovf;
                    exp_fin = 1'b1;
                    m_busy  = 0;
                end
            end
        end
    endtask

    task automatic go(input int a, input int b, input int dim, input int sh);
        beat(1, a, b, dim, sh, 0, 0);
    endtask

    task automatic stall();
        beat(0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_o_c", bus.o_c, 0);
        chk("rst_o_a", bus.o_a, 0);
        chk("rst_o_finish", bus.o_finish, 0);
        chk("rst_o_c_valid", bus.o_c_valid, 0);
        q.delete();
        m_prods.delete();
        m_busy  = 0;
        exp_a   = '0;
        exp_b   = '0;
        exp_ar  = 1'b0;
        exp_br  = 1'b0;
        exp_fin = 1'b0;
        exp_ovf = 1'b0;
        exp_c   = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("o_a", bus.o_a, exp_a);
        chk("o_b", bus.o_b, exp_b);
        chk("o_a_reset", bus.o_a_reset, exp_ar);
        chk("o_b_reset", bus.o_b_reset, exp_br);
        chk("o_finish", bus.o_finish, exp_fin);
        chk("o_c_hold", bus.o_c, exp_c);
        chk("o_overflow_hold", bus.o_overflow, exp_ovf);
        if (bus.o_c_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("o_c_valid_unexpected", bus.o_c_valid, 0);
            end else begin
                e = q.pop_front();
                chk("c_valid_cycle", cyc, e.cyc);
                chk("o_c", bus.o_c, e.c);
                chk("o_overflow", bus.o_overflow, e.ovf);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            chk("o_c_valid_missing", bus.o_c_valid, 1);
            void'(q.pop_front());
        end
    end

    initial begin
        bus.i_valid     = 1'b0;
        bus.i_a         = '0;
        bus.i_b         = '0;
        bus.i_dimension = '0;
        bus.i_shift     = '0;
        bus.i_a_reset   = 1'b0;
        bus.i_b_reset   = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_c", bus.o_c, 0);
        chk("reset_o_c_valid", bus.o_c_valid, 0);
        chk("reset_o_finish", bus.o_finish, 0);
        chk("reset_o_overflow", bus.o_overflow, 0);
        rst_n = 1'b1;

        repeat (4) go(64, 64, 4, 0);
        repeat (4) go(1, 1, 4, 0);
        repeat (4) go(-128, -128, 4, 0);
        repeat (4) go(-128, -128, 4, 2);
        go(3, 1, 1, 1);
        go(-3, 1, 1, 1);
        go(3, 1, 0, 1);
        go(-3, 1, 0, 1);
        repeat (2) go(1, 1, 4, 0);
        beat(1, 1, 1, 4, 0, 1, 0);
        repeat (4) go(2, 2, 4, 0);
        beat(1, 5, 5, 1, 0, 0, 1);
        go(7, -9, 1, 0);
        repeat (4) begin
            stall();
            go(64, 64, 4, 0);
        end
        async_reset();
        repeat (2) go(100, 100, 4, 0);
        async_reset();
        repeat (4) go(-7, 11, 4, 1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 2) stall();
            else beat(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                      $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end
        repeat (3) stall();
        chk("pending_results", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
